// File: rtl/clk_ctrl_pkg.sv
// Shared state encoding and divisor limits for the core clock-step controller.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } ctrl_state_t;

  // Smallest legal divisor; lower programmed values are raised to this.
  localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/tick_counter.sv
// Divide-by-div counter: wraps from div-1 to 0 while enabled, clear has priority.
// Latency: tc is decoded from registers only, valid the cycle count reaches div-1.
// Backpressure: none; clr/en are sampled every cycle.
module tick_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // div is never below 2, so div-1 cannot underflow.
  assign tc = (count == (div - WIDTH'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (tc) begin
        count <= '0;
      end else begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/clk_step_ctrl.sv
// Run/halt/single-step clock-enable controller: one-cycle tick every div cycles plus 50% phase.
// Latency: first tick div cycles after run/step is sampled; step_ack one cycle after the step's tick.
// Backpressure: none; step_req and div_load are only honoured in HALT, otherwise ignored.
module clk_step_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIV_DEFAULT = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  input  logic             run,
  input  logic             halt,
  input  logic             step_req,
  output logic             tick,
  output logic             phase,
  output logic             step_ack,
  output logic             busy
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_DEFAULT);
  localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(MIN_DIV);

  ctrl_state_t      state;
  ctrl_state_t      state_nxt;
  logic             ack_nxt;
  logic [WIDTH-1:0] div_q;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_tc;

  assign busy = (state != ST_HALT);
  assign tick = busy && cnt_tc;

  // Counter sits at 0 in HALT and is zeroed on the edge we drop into HALT,
  // so every RUN/STEP entry starts a full division period.
  assign cnt_en  = busy;
  assign cnt_clr = (state == ST_HALT) || (state_nxt == ST_HALT);

  tick_counter #(
    .WIDTH (WIDTH)
  ) u_tick_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .div   (div_q),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    case (state)
      ST_HALT: begin
        if (run) begin
          state_nxt = ST_RUN;
        end else if (step_req) begin
          state_nxt = ST_STEP;
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_nxt = ST_HALT;
        end
      end
      ST_STEP: begin
        // A halt in STEP is an abort: no acknowledge even on the tick edge.
        if (halt) begin
          state_nxt = ST_HALT;
        end else if (tick) begin
          state_nxt = ST_HALT;
          ack_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_HALT;
      step_ack <= 1'b0;
    end else begin
      state    <= state_nxt;
      step_ack <= ack_nxt;
    end
  end

  // Divisor may only change while the core clock is stopped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= DIV_RST;
    end else if (div_load && (state == ST_HALT)) begin
      div_q <= (div_value < DIV_MIN) ? DIV_MIN : div_value;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= 1'b0;
    end else if (tick) begin
      phase <= ~phase;
    end
  end

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Bench for clk_step_ctrl: directed scenarios plus random traffic against a cycle-count model.
module tb_clk_step_ctrl;

  localparam int WIDTH       = 8;
  localparam int DIV_DEFAULT = 12;

  logic             clk       = 1'b0;
  logic             reset     = 1'b0;
  logic             div_load  = 1'b0;
  logic [WIDTH-1:0] div_value = '0;
  logic             run       = 1'b0;
  logic             halt      = 1'b0;
  logic             step_req  = 1'b0;
  logic             tick;
  logic             phase;
  logic             step_ack;
  logic             busy;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  clk_step_ctrl #(
    .WIDTH       (WIDTH),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .div_load  (div_load),
    .div_value (div_value),
    .run       (run),
    .halt      (halt),
    .step_req  (step_req),
    .tick      (tick),
    .phase     (phase),
    .step_ack  (step_ack),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Model: mode 0=halted, 1=running, 2=stepping; m_n counts cycles since the
  // run/step began, so a tick is due whenever m_n mod div lands on div-1.
  int m_mode;
  int m_n;
  int m_div;
  bit m_phase;
  bit m_ack;
  bit m_t;

  function automatic bit m_tick();
    return (m_mode != 0) && ((m_n % m_div) == (m_div - 1));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode  = 0;
      m_n     = 0;
      m_div   = DIV_DEFAULT;
      m_phase = 1'b0;
      m_ack   = 1'b0;
    end else begin
      m_t   = m_tick();
      m_ack = 1'b0;
      if (m_t) m_phase = ~m_phase;
      if (m_mode == 0) begin
        if (div_load) m_div = (int'(div_value) < 2) ? 2 : int'(div_value);
        if (run) begin
          m_mode = 1;
          m_n    = 0;
        end else if (step_req) begin
          m_mode = 2;
          m_n    = 0;
        end
      end else if (m_mode == 1) begin
        if (halt) m_mode = 0;
        else m_n++;
      end else begin
        if (halt) begin
          m_mode = 0;
        end else if (m_t) begin
          m_mode = 0;
          m_ack  = 1'b1;
        end else begin
          m_n++;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && reset) begin
      check("model_tick",  int'(tick),     int'(m_tick()));
      check("model_phase", int'(phase),    int'(m_phase));
      check("model_ack",   int'(step_ack), int'(m_ack));
      check("model_busy",  int'(busy),     int'(m_mode != 0));
    end
  end

  // Called on the first negedge after the request's sample edge (cycle 1);
  // returns the cycle index in which tick is high, or -1 on timeout.
  task automatic wait_tick(input int maxc, output int k);
    k = 1;
    while (tick !== 1'b1 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    if (tick !== 1'b1) k = -1;
  endtask

  task automatic count_evt(input int n, output int ticks, output int acks);
    ticks = 0;
    acks  = 0;
    repeat (n) begin
      @(negedge clk);
      if (tick === 1'b1) ticks++;
      if (step_ack === 1'b1) acks++;
    end
  endtask

  task automatic load_div(input int v);
    @(negedge clk);
    div_load  = 1'b1;
    div_value = WIDTH'(v);
    @(negedge clk);
    div_load  = 1'b0;
  endtask

  task automatic do_step(output int k);
    @(negedge clk);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    wait_tick(300, k);
  endtask

  int k, nt, na;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset  = 1'b1;
    chk_en = 1'b1;
    check("rst_busy",  int'(busy),     0);
    check("rst_tick",  int'(tick),     0);
    check("rst_phase", int'(phase),    0);
    check("rst_ack",   int'(step_ack), 0);

    // Step at the reset divisor.
    do_step(k);
    check("step12_latency", k, 12);
    @(negedge clk);
    check("step12_ack",  int'(step_ack), 1);
    check("step12_busy", int'(busy),     0);

    // Continuous run, then a one-cycle halt.
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    wait_tick(300, k);
    check("run12_first", k, 12);
    @(negedge clk);
    wait_tick(300, k);
    check("run12_period", k, 12);
    @(negedge clk);
    halt = 1'b1;
    run  = 1'b0;
    @(negedge clk);
    halt = 1'b0;
    check("halt_busy", int'(busy), 0);
    count_evt(30, nt, na);
    check("halt_no_tick", nt, 0);

    // Load 3 and single-step.
    load_div(3);
    do_step(k);
    check("step3_latency", k, 3);
    @(negedge clk);
    check("step3_ack",  int'(step_ack), 1);
    check("step3_busy", int'(busy),     0);
    count_evt(10, nt, na);
    check("step3_single", nt, 0);

    // Load during RUN is ignored.
    load_div(12);
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    wait_tick(300, k);
    @(negedge clk);
    div_load  = 1'b1;
    div_value = WIDTH'(5);
    wait_tick(300, k);
    check("run_load_ignored", k, 12);
    @(negedge clk);
    halt     = 1'b1;
    run      = 1'b0;
    div_load = 1'b0;
    @(negedge clk);
    halt = 1'b0;

    // Divisor 0 clamps to 2; run+step together picks RUN.
    load_div(0);
    @(negedge clk);
    run      = 1'b1;
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    wait_tick(300, k);
    check("clamp_first", k, 2);
    count_evt(20, nt, na);
    check("clamp_continuous", nt, 10);
    check("runstep_no_ack", na, 0);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    run  = 1'b0;
    check("run_halt_busy", int'(busy), 0);

    // Halt aborts a step before its tick.
    load_div(12);
    @(negedge clk);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    repeat (4) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    count_evt(30, nt, na);
    check("abort_ticks", nt, 0);
    check("abort_acks",  na, 0);

    // Reset mid-step loses the ack and restores the default divisor.
    load_div(5);
    @(negedge clk);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy",  int'(busy),     0);
    check("arst_tick",  int'(tick),     0);
    check("arst_phase", int'(phase),    0);
    check("arst_ack",   int'(step_ack), 0);
    @(negedge clk);
    reset = 1'b1;
    count_evt(20, nt, na);
    check("arst_no_ack", na, 0);
    do_step(k);
    check("arst_div_default", k, 12);

    // Random traffic, checked each cycle by the model compare process.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      run       = ($urandom_range(0, 29) == 0);
      halt      = ($urandom_range(0, 24) == 0);
      step_req  = ($urandom_range(0, 7) == 0);
      div_load  = ($urandom_range(0, 5) == 0);
      div_value = WIDTH'($urandom_range(0, 7));
    end
    @(negedge clk);
    run      = 1'b0;
    halt     = 1'b0;
    step_req = 1'b0;
    div_load = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_step_ctrl.md
# clk_step_ctrl

Run/halt/single-step controller for the MIPS core clock. It replaces free-running clock division with a synchronous clock-enable scheme. Using one system clock, it produces a one-cycle `tick` enable every `div` cycles plus a 50 % `phase` square wave, with a divisor that can be programmed while halted. The debug/board-control logic uses it to run the core continuously, stop it, or advance it by exactly one tick with an acknowledge handshake.

## Interface
- `WIDTH`, 8: width of divisor and counter.
- `DIV_DEFAULT`, 12: divisor after reset; must satisfy 2 ≤ DIV_DEFAULT < 2**WIDTH.

- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `div_load`  in  1  load `div_value` into the divisor register; honoured only in HALT.
- `div_value`  in  WIDTH  new divisor; values 0 and 1 clamp to 2.
- `run`  in  1  level request to run continuously.
- `halt`  in  1  level request to stop.
- `step_req`  in  1  request one tick; sampled only in HALT.
- `tick`  out  1  clock enable for the core, high for one cycle per division period.
- `phase`  out  1  toggles on every tick; period 2*div cycles.
- `step_ack`  out  1  one-cycle pulse, cycle after the step's tick.
- `busy`  out  1  high when state ≠ HALT.

## Operation
- States: HALT, RUN, STEP. Reset enters HALT.
- Reset values: counter 0, `div` = DIV_DEFAULT, `phase` 0, `tick` 0, `step_ack` 0, `busy` 0.
- Transitions in HALT:
  - `run` → RUN.
  - Else `step_req` → STEP.
  - `run` has priority over `step_req`.
  - Entering RUN or STEP clears the counter to 0.
- Transitions in RUN:
  - `halt` → HALT.
  - `halt` wins over a simultaneous `run`.
- Transitions in STEP:
  - On the edge where `tick` = 1, go to HALT and set `step_ack` for the next cycle.
  - `halt` in STEP aborts: go to HALT with no ack and no further tick.
  - `step_req` and `run` are ignored in STEP.
- Counter:
  - In RUN or STEP it counts 0..div-1 and wraps to 0.
  - In HALT it is held at 0.
- `tick` = (state ≠ HALT) && (counter == div-1). It is decoded from registers only, with no input-to-output path.
- `phase` toggles on each edge where `tick` = 1 and holds otherwise. It is not cleared by halt.
- Divisor register:
  - Loads only when `div_load` = 1 in HALT.
  - `div_value` < 2 stores 2.
  - `div_load` in RUN or STEP is ignored; the old `div` stays.
- Arithmetic: the counter compare uses WIDTH bits and no overflow is possible, since div ≤ 2**WIDTH-1.

## Timing
- Latency: `run` sampled at edge E0 gives the first `tick` in cycle div after E0 (E0+div-1 edges later). Later ticks come every `div` cycles.
- Halt latency: `halt` sampled at edge E gives HALT from E on, so no tick after E. If `tick` was high in the cycle before E, that tick still counts.
- Step: `step_req` at E0 gives a `tick` high for one cycle after E0+div-1 edges. `step_ack` is high in the following cycle, when `busy` is already 0.
- Back-to-back steps: a new `step_req` is accepted on the edge after the ack cycle or later, i.e. any edge in HALT.
- Asynchronous `reset` assertion forces all reset values immediately, including mid-STEP. A pending ack is lost.

## Structure
- Shared package `clk_ctrl_pkg`: state encoding constants (HALT = 2'b00, RUN = 2'b01, STEP = 2'b10) and the minimum divisor constant (2).
- One sub-module, `tick_counter`: WIDTH-bit counter with clear/enable, divisor input and a terminal-count output.
- The FSM, divisor register, `phase` and `step_ack` live in the top level.

## Test plan
- Reset: assert `reset` = 0 mid-count → all outputs 0 immediately and `div` = 12. After release, a step with no load gives a tick 12 cycles later.
- Run, div = 12: `run` held → `tick` every 12 cycles, `phase` period 24. `halt` for one cycle → no further ticks and `busy` = 0 next cycle.
- Load and step: in HALT load `div_value` = 3, pulse `step_req` → exactly one `tick` 3 cycles after the sample edge, `step_ack` the next cycle, then back to HALT.
- Ignored/clamped load: `div_load` with 5 during RUN → period stays 12. `div_value` = 0 loaded in HALT, then run → tick every 2 cycles.
- Simultaneous requests:
  - `run` + `step_req` in HALT → RUN with continuous ticks.
  - `run` + `halt` in RUN → HALT.
- Aborts:
  - `halt` during STEP before the tick → no tick, no `step_ack`.
  - `reset` asserted mid-STEP → no ack after release.
